// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select codes, fixed fetch
// addresses and the PC-stage FSM state type.
package mips_pkg;

  // blinkctrl encodings produced by the branch/jump selector
  localparam logic [1:0] NPC_SEQ = 2'd0;  // PC + 4
  localparam logic [1:0] NPC_BR  = 2'd1;  // taken conditional branch
  localparam logic [1:0] NPC_J   = 2'd2;  // j / jal
  localparam logic [1:0] NPC_JR  = 2'd3;  // jr / jalr

  // Fetch address after reset and the exception handler entry point
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR       = 32'h0000_4180;

  // PC-stage control states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } npc_state_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target mux. All arithmetic wraps at 32 bits.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_d_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] index26_i,
  input  logic [31:0] rs_data_i,
  input  logic [1:0]  blinkctrl_i,
  output logic [31:0] npc_o
);

  logic [31:0] pc4_d;
  logic [31:0] br_off;

  // D-stage PC+4 is the base for branches and supplies the jump region nibble
  assign pc4_d  = pc_d_i + 32'd4;
  assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  // Select the target; jr passes rs through unmasked
  always_comb begin
    npc_o = pc_f_i + 32'd4;
    unique case (blinkctrl_i)
      NPC_SEQ: npc_o = pc_f_i + 32'd4;
      NPC_BR:  npc_o = pc4_d + br_off;
      NPC_J:   npc_o = {pc4_d[31:28], index26_i, 2'b00};
      NPC_JR:  npc_o = rs_data_i;
      default: npc_o = pc_f_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/npc_pc_reg.sv
// F-stage program counter register with BOOT/RUN/HOLD control and a
// saturating redirect counter. Optional exception/eret redirect support is
// enabled with the NPC_EXC_EN macro (exc_req > eret > blinkctrl).
module npc_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 16
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       blinkctrl,
  input  logic [31:0]      pc_d,
  input  logic [15:0]      imm16,
  input  logic [25:0]      index26,
  input  logic [31:0]      rs_data,
`ifdef NPC_EXC_EN
  input  logic             exc_req,
  input  logic             eret,
  input  logic [31:0]      epc,
`endif
  output logic [31:0]      pc_f,
  output logic [31:0]      pc4_f,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] redirect_cnt
);

  npc_state_e       state_q, state_d;
  logic [31:0]      pc_f_q, pc_f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      npc;
  logic             redirect;

  npc_calc u_npc_calc (
    .pc_f_i      (pc_f_q),
    .pc_d_i      (pc_d),
    .imm16_i     (imm16),
    .index26_i   (index26),
    .rs_data_i   (rs_data),
    .blinkctrl_i (blinkctrl),
    .npc_o       (npc)
  );

  // Next state, next PC and counter update; stall freezes the PC and masks blinkctrl
  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    cnt_d    = cnt_q;
    redirect = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (stall) begin
          state_d = ST_HOLD;
        end else begin
          state_d  = ST_RUN;
          pc_f_d   = npc;
          redirect = (blinkctrl != NPC_SEQ);
        end
      end
      default: state_d = ST_BOOT;
    endcase
`ifdef NPC_EXC_EN
    // Exceptions and eret override stall and BOOT
    if (exc_req) begin
      state_d  = ST_RUN;
      pc_f_d   = EXC_VECTOR;
      redirect = 1'b1;
    end else if (eret) begin
      state_d  = ST_RUN;
      pc_f_d   = epc;
      redirect = 1'b1;
    end
`endif
    if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, PC and counter registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_f_q  <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_f         = pc_f_q;
  assign pc4_f        = pc_f_q + 32'd4;
  assign fetch_valid  = (state_q != ST_BOOT);
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_npc_pc_reg.sv
// Directed testbench for npc_pc_reg (counter width reduced to 4 bits so
// saturation is reachable quickly).
module tb_npc_pc_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  blinkctrl;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] rs_data;
`ifdef NPC_EXC_EN
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
`endif
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic        fetch_valid;
  logic [3:0]  redirect_cnt;

  int total  = 0;
  int passed = 0;

  npc_pc_reg #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .blinkctrl    (blinkctrl),
    .pc_d         (pc_d),
    .imm16        (imm16),
    .index26      (index26),
    .rs_data      (rs_data),
`ifdef NPC_EXC_EN
    .exc_req      (exc_req),
    .eret         (eret),
    .epc          (epc),
`endif
    .pc_f         (pc_f),
    .pc4_f        (pc4_f),
    .fetch_valid  (fetch_valid),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc_f,
                           input logic efv, input logic [3:0] ecnt);
    check({tag, "_pc"}, pc_f, epc_f);
    check({tag, "_pc4"}, pc4_f, epc_f + 32'd4);
    check({tag, "_fv"}, {31'b0, fetch_valid}, {31'b0, efv});
    check({tag, "_cnt"}, {28'b0, redirect_cnt}, {28'b0, ecnt});
    $display("step %s: pc_f=%h fv=%0b cnt=%0d", tag, pc_f, fetch_valid, redirect_cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; blinkctrl = 2'd0;
    pc_d = '0; imm16 = '0; index26 = '0; rs_data = '0;
`ifdef NPC_EXC_EN
    exc_req = 1'b0; eret = 1'b0; epc = '0;
`endif
    #1;
    chk_state("reset", 32'h3000, 1'b0, 4'd0);
    step(); step();
    reset = 1'b0;

    // BOOT -> RUN keeps PC, then sequential stepping
    step(); chk_state("boot", 32'h3000, 1'b1, 4'd0);
    step(); chk_state("seq1", 32'h3004, 1'b1, 4'd0);
    step(); chk_state("seq2", 32'h3008, 1'b1, 4'd0);

    // Backward branch
    pc_d = 32'h3010; imm16 = 16'hFFFC; blinkctrl = 2'd1;
    step(); chk_state("br_back", 32'h3004, 1'b1, 4'd1);

    // Jump
    pc_d = 32'h3020; index26 = 26'h0000C40; blinkctrl = 2'd2;
    step(); chk_state("jump", 32'h3100, 1'b1, 4'd2);

    // Stall with jr pending and rs_data churning
    stall = 1'b1; blinkctrl = 2'd3; rs_data = 32'h1111;
    step(); chk_state("hold1", 32'h3100, 1'b1, 4'd2);
    rs_data = 32'h2222;
    step(); chk_state("hold2", 32'h3100, 1'b1, 4'd2);
    rs_data = 32'h3333;
    step(); chk_state("hold3", 32'h3100, 1'b1, 4'd2);
    stall = 1'b0; rs_data = 32'h3400;
    step(); chk_state("jr_release", 32'h3400, 1'b1, 4'd3);

    // jr does not mask the low bits
    rs_data = 32'h3402;
    step(); chk_state("jr_unaligned", 32'h3402, 1'b1, 4'd4);

    // Forward branch
    pc_d = 32'h3000; imm16 = 16'h0010; blinkctrl = 2'd1;
    step(); chk_state("br_fwd", 32'h3044, 1'b1, 4'd5);

    // Branch target wraps past 2^32
    pc_d = 32'hFFFF_FFFC; imm16 = 16'h0000;
    step(); chk_state("br_wrap", 32'h0000_0000, 1'b1, 4'd6);

    // Jump region nibble comes from pc_d + 4
    pc_d = 32'h1FFF_FFFC; index26 = 26'h0000001; blinkctrl = 2'd2;
    step(); chk_state("j_region", 32'h2000_0004, 1'b1, 4'd7);

    // Counter saturation at 15
    for (int i = 0; i < 8; i++) step();
    chk_state("sat_reach", 32'h2000_0004, 1'b1, 4'd15);
    step(); step();
    chk_state("sat_hold", 32'h2000_0004, 1'b1, 4'd15);

    // Sequential step does not count
    blinkctrl = 2'd0;
    step(); chk_state("seq_nocnt", 32'h2000_0008, 1'b1, 4'd15);

    // Asynchronous reset while in HOLD
    stall = 1'b1; blinkctrl = 2'd3;
    step(); chk_state("pre_rst_hold", 32'h2000_0008, 1'b1, 4'd15);
    #2;
    reset = 1'b1;
    #1;
    chk_state("async_rst", 32'h3000, 1'b0, 4'd0);
    step();
    reset = 1'b0;

    // BOOT leaves regardless of stall; then RUN->HOLD ignores blinkctrl
    step(); chk_state("boot_stall", 32'h3000, 1'b1, 4'd0);
    step(); chk_state("run_stall", 32'h3000, 1'b1, 4'd0);

`ifdef NPC_EXC_EN
    // exc_req beats eret, even under stall
    exc_req = 1'b1; eret = 1'b1; epc = 32'h3008;
    step(); chk_state("exc", 32'h4180, 1'b1, 4'd1);
    exc_req = 1'b0;
    step(); chk_state("eret", 32'h3008, 1'b1, 4'd2);
    eret = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
